// File: rtl/ascii_to_ps2_tx.sv
// ascii_to_ps2_tx: maps game-key ASCII to PS/2 set-2 scan codes and
// sends make/break frames device-to-host. Build option: UPPERCASE_SHIFT_EN.
module ascii_to_ps2_tx #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       busy,
    output logic       bad_char,
    output logic       ps2_clk_out,
    output logic       ps2_data_out
);

    localparam int PH_W = $clog2(HALF_PERIOD + 1);
    localparam int GP_W = $clog2(GAP_CYCLES + 1);

`ifdef UPPERCASE_SHIFT_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd2;
`endif

    localparam logic [3:0] STOP_BIT = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        BIT_HI,
        BIT_LO,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [GP_W-1:0] gap_q, gap_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [7:0]      code_q, code_d;
    logic            clk_q, clk_d;
    logic            data_q, data_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            bad_q, bad_d;

    logic            map_hit;
    logic [7:0]      map_code;

    // Scan-code lookup; bit 8 flags a mapped character.
    function automatic logic [8:0] map_ascii(input logic [7:0] c);
        logic [8:0] r;
        case (c)
            8'h31:   r = {1'b1, 8'h16};
            8'h32:   r = {1'b1, 8'h1E};
            8'h33:   r = {1'b1, 8'h26};
            8'h34:   r = {1'b1, 8'h25};
            8'h35:   r = {1'b1, 8'h2E};
            8'h36:   r = {1'b1, 8'h36};
            8'h37:   r = {1'b1, 8'h3D};
            8'h38:   r = {1'b1, 8'h3E};
            8'h39:   r = {1'b1, 8'h46};
            8'h6F:   r = {1'b1, 8'h44};
            8'h78:   r = {1'b1, 8'h22};
`ifdef UPPERCASE_SHIFT_EN
            8'h4F:   r = {1'b1, 8'h44};
            8'h58:   r = {1'b1, 8'h22};
`endif
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Byte of the keystroke sequence selected by the byte index.
    function automatic logic [7:0] seq_byte(input logic [2:0] idx,
                                            input logic [7:0] code);
        logic [7:0] r;
`ifdef UPPERCASE_SHIFT_EN
        case (idx)
            3'd1, 3'd3: r = code;
            3'd2, 3'd4: r = 8'hF0;
            default:    r = 8'h12;
        endcase
`else
        case (idx)
            3'd1:    r = 8'hF0;
            default: r = code;
        endcase
`endif
        return r;
    endfunction

    // Frame bit: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] b,
                                       input logic [3:0] idx);
        logic [3:0] k;
        logic       r;
        k = idx - 4'd1;
        if (idx == 4'd0) begin
            r = 1'b0;
        end else if (idx <= 4'd8) begin
            r = b[k[2:0]];
        end else if (idx == 4'd9) begin
            r = ~^b;
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    assign {map_hit, map_code} = map_ascii(ascii_in);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        code_d  = code_q;
        clk_d   = clk_q;
        data_d  = data_q;
        bad_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ascii_valid) begin
                    if (map_hit) begin
                        code_d  = map_code;
                        byte_d  = 3'd0;
                        bit_d   = 4'd0;
                        phase_d = '0;
                        clk_d   = 1'b1;
                        data_d  = frame_bit(seq_byte(3'd0, map_code), 4'd0);
                        state_d = BIT_HI;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            BIT_HI: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    phase_d = '0;
                    clk_d   = 1'b0;
                    state_d = BIT_LO;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            BIT_LO: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    phase_d = '0;
                    clk_d   = 1'b1;
                    if (bit_q == STOP_BIT) begin
                        gap_d   = '0;
                        data_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        data_d  = frame_bit(seq_byte(byte_q, code_q),
                                            bit_q + 4'd1);
                        state_d = BIT_HI;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GP_W'(GAP_CYCLES - 1)) begin
                    gap_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        bit_d   = 4'd0;
                        data_d  = 1'b0;
                        state_d = BIT_HI;
                    end
                end else begin
                    gap_d = gap_q + GP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b1;
                data_d  = 1'b1;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            phase_q <= '0;
            gap_q   <= '0;
            bit_q   <= 4'd0;
            byte_q  <= 3'd0;
            code_q  <= 8'h00;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            code_q  <= code_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            bad_q   <= bad_d;
        end
    end

    assign ascii_ready  = ready_q;
    assign busy         = busy_q;
    assign bad_char     = bad_q;
    assign ps2_clk_out  = clk_q;
    assign ps2_data_out = data_q;

endmodule
